// File: rtl/mcs51_prog_sequencer.sv
// mcs51_prog_sequencer: PROG/VPP/increment pulse sequencer for AT89Cx051 flash programming
module mcs51_prog_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int PULSE_CYCLES   = 24,
  parameter int RECOVER_CYCLES = 2,
  parameter int POLL_CYCLES    = 4800,
  parameter int READY_POLLS    = 12,
  parameter int VERIFY_CYCLES  = 2,
  parameter int MAX_RETRIES    = 3,
  parameter int IA_CYCLES      = 2,
  parameter int ERASE_CYCLES   = 240000,
  parameter int AUTO_INC       = 1
) (
  input  logic                  osc,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  input  logic                  dut_rdy,
  input  logic [DATA_WIDTH-1:0] dut_data_in,
  output logic [DATA_WIDTH-1:0] dut_data_out,
  output logic                  dut_data_oe,
  output logic                  dut_verify,
  output logic                  dut_prog,
  output logic                  dut_vpp,
  output logic                  dut_ia
);
  function automatic int max2(int a, int b);
    return a > b ? a : b;
  endfunction
  localparam int MAXC = max2(max2(max2(PULSE_CYCLES, RECOVER_CYCLES), max2(POLL_CYCLES, VERIFY_CYCLES)),
                             max2(IA_CYCLES, ERASE_CYCLES));
  localparam int CW = $clog2(MAXC) + 1;
  localparam int PW = $clog2(READY_POLLS) + 1;
  localparam int RW = $clog2(MAX_RETRIES + 1) + 1;
  localparam logic [CW-1:0] P_END = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] R_END = CW'(RECOVER_CYCLES - 1);
  localparam logic [CW-1:0] W_END = CW'(POLL_CYCLES - 1);
  localparam logic [CW-1:0] V_END = CW'(VERIFY_CYCLES - 1);
  localparam logic [CW-1:0] I_END = CW'(IA_CYCLES - 1);
  localparam logic [CW-1:0] E_END = CW'(ERASE_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(READY_POLLS - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [2:0] C_PH = 3'd1, C_PL = 3'd2, C_PROGRAM = 3'd3, C_ERASE = 3'd4;
  localparam logic [2:0] C_VON = 3'd5, C_VOFF = 3'd6, C_READ = 3'd7;
  typedef enum logic [3:0] {IDLE, PULSE, RECOVER, POLL, WAIT, VERIFY, INC, ERASE, FINISH} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [PW-1:0] polls, polls_n;
  logic [RW-1:0] retries, retries_n;
  logic [2:0] cmd_q, cmd_q_n;
  logic [DATA_WIDTH-1:0] data_q, data_q_n, rd_data_n;
  logic [1:0] err_code_n, rdy_s;
  logic busy_n, done_n, err_n, cmd_ready_n, oe_n, verify_n, prog_n, vpp_n, ia_n;
  logic fin, last, match;
  assign dut_data_out = data_q;
  assign last = cnt == '0;
  assign match = cmd_q == C_READ || dut_data_in == data_q;
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt - 1'b1;
    polls_n = polls;
    retries_n = retries;
    cmd_q_n = cmd_q;
    data_q_n = data_q;
    rd_data_n = rd_data;
    busy_n = busy;
    done_n = 1'b0;
    err_n = err;
    err_code_n = err_code;
    cmd_ready_n = cmd_ready;
    oe_n = dut_data_oe;
    verify_n = dut_verify;
    prog_n = dut_prog;
    vpp_n = dut_vpp;
    ia_n = 1'b0;
    fin = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (state == FINISH) state_n = IDLE;
        if (cmd_valid && cmd_ready) begin
          cmd_q_n = cmd;
          data_q_n = wr_data;
          err_n = 1'b0;
          err_code_n = 2'd0;
          cmd_ready_n = 1'b0;
          busy_n = 1'b1;
          retries_n = '0;
          case (cmd)
            C_PROGRAM: begin
              state_n = PULSE;
              cnt_n = P_END;
              oe_n = 1'b1;
              prog_n = 1'b0;
            end
            C_ERASE: begin
              state_n = ERASE;
              cnt_n = E_END;
              prog_n = 1'b0;
            end
            C_READ: begin
              state_n = VERIFY;
              cnt_n = V_END;
              oe_n = 1'b0;
              verify_n = 1'b1;
            end
            default: begin
              fin = 1'b1;
              prog_n = cmd == C_PH ? 1'b1 : cmd == C_PL ? 1'b0 : dut_prog;
              vpp_n = cmd == C_VON ? 1'b1 : cmd == C_VOFF ? 1'b0 : dut_vpp;
            end
          endcase
        end
      end
      PULSE: if (last) begin
        state_n = RECOVER;
        cnt_n = R_END;
        prog_n = 1'b1;
      end
      RECOVER: if (last) begin
        state_n = POLL;
        polls_n = '0;
      end
      POLL: if (rdy_s[1]) begin
        state_n = VERIFY;
        cnt_n = V_END;
        oe_n = 1'b0;
        verify_n = 1'b1;
      end else if (polls == POLL_LAST) begin
        err_code_n = 2'd1;
        fin = 1'b1;
      end else begin
        state_n = WAIT;
        cnt_n = W_END;
        polls_n = polls + 1'b1;
      end
      WAIT: if (last) state_n = POLL;
      VERIFY: if (last) begin
        rd_data_n = dut_data_in;
        verify_n = 1'b0;
        if (match) begin
          if (AUTO_INC != 0) begin
            state_n = INC;
            cnt_n = I_END;
            ia_n = 1'b1;
          end else fin = 1'b1;
        end else if (retries != RETRY_MAX) begin
          retries_n = retries + 1'b1;
          state_n = PULSE;
          cnt_n = P_END;
          oe_n = 1'b1;
          prog_n = 1'b0;
        end else begin
          err_code_n = 2'd2;
          fin = 1'b1;
        end
      end
      INC: begin
        ia_n = !last;
        fin = last;
      end
      ERASE: if (last) begin
        prog_n = 1'b1;
        fin = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    // every completion path funnels through here so FINISH outputs are uniform
    if (fin) begin
      state_n = FINISH;
      done_n = 1'b1;
      busy_n = 1'b0;
      cmd_ready_n = 1'b1;
      verify_n = 1'b0;
      oe_n = 1'b0;
      err_n = err_code_n != 2'd0;
    end
  end
  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      polls <= '0;
      retries <= '0;
      cmd_q <= '0;
      data_q <= '0;
      rd_data <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      err_code <= 2'd0;
      cmd_ready <= 1'b1;
      dut_data_oe <= 1'b0;
      dut_verify <= 1'b0;
      dut_prog <= 1'b0;
      dut_vpp <= 1'b0;
      dut_ia <= 1'b0;
      rdy_s <= 2'b00;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      polls <= polls_n;
      retries <= retries_n;
      cmd_q <= cmd_q_n;
      data_q <= data_q_n;
      rd_data <= rd_data_n;
      busy <= busy_n;
      done <= done_n;
      err <= err_n;
      err_code <= err_code_n;
      cmd_ready <= cmd_ready_n;
      dut_data_oe <= oe_n;
      dut_verify <= verify_n;
      dut_prog <= prog_n;
      dut_vpp <= vpp_n;
      dut_ia <= ia_n;
      rdy_s <= {rdy_s[0], dut_rdy};
    end
  end
endmodule

// File: tb/tb_mcs51_prog_sequencer.sv
// tb_mcs51_prog_sequencer: vector table, corner sequences and randomized model check of the sequencer
module tb_mcs51_prog_sequencer;
  localparam int P = 4, R = 2, PL = 8, NP = 3, V = 2, IA = 1, RT = 2, ER = 16;
  logic osc, rst, cmd_valid, cmd_ready, busy, done, err, dut_rdy;
  logic dut_data_oe, dut_verify, dut_prog, dut_vpp, dut_ia;
  logic [2:0] cmd;
  logic [1:0] err_code;
  logic [7:0] wr_data, rd_data, dut_data_in, dut_data_out, good_v, bad_v;
  int bad_n, npulse, cyc, tests, fails;
  bit pm, vm;
  logic [7:0] rdm;
  mcs51_prog_sequencer #(
    .DATA_WIDTH(8), .PULSE_CYCLES(P), .RECOVER_CYCLES(R), .POLL_CYCLES(PL),
    .READY_POLLS(NP), .VERIFY_CYCLES(V), .MAX_RETRIES(RT), .IA_CYCLES(IA),
    .ERASE_CYCLES(ER), .AUTO_INC(1)
  ) dut (
    .osc(osc), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
    .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .dut_rdy(dut_rdy), .dut_data_in(dut_data_in),
    .dut_data_out(dut_data_out), .dut_data_oe(dut_data_oe), .dut_verify(dut_verify),
    .dut_prog(dut_prog), .dut_vpp(dut_vpp), .dut_ia(dut_ia)
  );
  // the device returns bad_v for the first bad_n program attempts, then the intended byte
  assign dut_data_in = (npulse != 0 && npulse <= bad_n) ? bad_v : good_v;
  initial begin
    osc = 1'b0;
    forever #5 osc = ~osc;
  end
  always @(posedge osc) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic exec(input string nm, input logic [2:0] c, input logic [7:0] d, input bit rdy,
                      input int m, input logic [7:0] bad, input bit hold, input int e_off,
                      input int e_ec, input int e_p, input int e_plow, input int e_ia,
                      input logic [7:0] e_rd, input bit e_vpp, input bit e_prog);
    int e0, off, ndone, pulses, plow, iac, vhi;
    bit prev;
    @(negedge osc);
    dut_rdy = rdy;
    good_v = d;
    bad_v = bad;
    bad_n = m;
    npulse = 0;
    prev = dut_prog;
    cmd = c;
    wr_data = d;
    cmd_valid = 1'b1;
    @(posedge osc);
    #1;
    e0 = cyc;
    if (hold) cmd = 3'd5;
    else cmd_valid = 1'b0;
    off = -1;
    ndone = 0;
    pulses = 0;
    plow = 0;
    iac = 0;
    vhi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge osc);
      if (done) begin
        ndone++;
        if (off < 0) off = cyc - e0;
        cmd_valid = 1'b0;
      end
      if (!dut_prog) plow++;
      if (prev && !dut_prog) pulses++;
      npulse = pulses;
      prev = dut_prog;
      if (dut_ia) iac++;
      if (dut_vpp) vhi++;
      if (off >= 0 && cyc - e0 >= off + 3) break;
    end
    cmd_valid = 1'b0;
    chk({nm, ".done_offset"}, off, e_off);
    chk({nm, ".done_pulses"}, ndone, 1);
    chk({nm, ".err_code"}, int'(err_code), e_ec);
    chk({nm, ".err"}, int'(err), int'(e_ec != 0));
    chk({nm, ".rd_data"}, int'(rd_data), int'(e_rd));
    chk({nm, ".prog_pulses"}, pulses, e_p);
    chk({nm, ".ia_cycles"}, iac, e_ia);
    chk({nm, ".vpp"}, int'(dut_vpp), int'(e_vpp));
    chk({nm, ".prog"}, int'(dut_prog), int'(e_prog));
    chk({nm, ".idle"}, int'({cmd_ready, busy, dut_verify, dut_data_oe}), 8);
    if (c == 3'd3 || c == 3'd4) chk({nm, ".prog_low_cycles"}, plow, e_plow);
    if (hold) chk({nm, ".vpp_high_cycles"}, vhi, 0);
  endtask
  typedef struct {
    logic [2:0] c; logic [7:0] d; bit rdy; int m; logic [7:0] bad;
    int off; int ec; int p; int plow; int ia; logic [7:0] rd; bit vpp; bit prog;
  } vec_t;
  vec_t tbl[12];
  logic [2:0] pick[10];
  initial begin
    int c0, nd, att, m, off, ec, ia;
    bit rdy, succ;
    logic [7:0] d, bad;
    logic [2:0] c;
    tests = 0;
    fails = 0;
    cyc = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    wr_data = 8'h00;
    dut_rdy = 1'b0;
    good_v = 8'h00;
    bad_v = 8'h00;
    bad_n = 0;
    npulse = 0;
    tbl[0]  = '{3'd1, 8'h00, 1'b1, 0,  8'h00, 0,  0, 0, 0,  0, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{3'd3, 8'hA5, 1'b1, 0,  8'h00, 10, 0, 1, 4,  1, 8'hA5, 1'b0, 1'b1};
    tbl[2]  = '{3'd3, 8'h3C, 1'b0, 0,  8'h00, 25, 1, 1, 4,  0, 8'hA5, 1'b0, 1'b1};
    tbl[3]  = '{3'd3, 8'h3C, 1'b1, 2,  8'h00, 28, 0, 3, 12, 1, 8'h3C, 1'b0, 1'b1};
    tbl[4]  = '{3'd3, 8'h3C, 1'b1, 99, 8'hFF, 27, 2, 3, 12, 0, 8'hFF, 1'b0, 1'b1};
    tbl[5]  = '{3'd7, 8'h5A, 1'b1, 0,  8'h00, 3,  0, 0, 0,  1, 8'h5A, 1'b0, 1'b1};
    tbl[6]  = '{3'd5, 8'h00, 1'b1, 0,  8'h00, 0,  0, 0, 0,  0, 8'h5A, 1'b1, 1'b1};
    tbl[7]  = '{3'd4, 8'h00, 1'b1, 0,  8'h00, 16, 0, 1, 16, 0, 8'h5A, 1'b1, 1'b1};
    tbl[8]  = '{3'd6, 8'h00, 1'b1, 0,  8'h00, 0,  0, 0, 0,  0, 8'h5A, 1'b0, 1'b1};
    tbl[9]  = '{3'd2, 8'h00, 1'b1, 0,  8'h00, 0,  0, 1, 0,  0, 8'h5A, 1'b0, 1'b0};
    tbl[10] = '{3'd0, 8'h00, 1'b1, 0,  8'h00, 0,  0, 0, 0,  0, 8'h5A, 1'b0, 1'b0};
    tbl[11] = '{3'd1, 8'h00, 1'b1, 0,  8'h00, 0,  0, 0, 0,  0, 8'h5A, 1'b0, 1'b1};
    pick = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6, 3'd0};
    repeat (3) @(negedge osc);
    chk("reset_outputs", int'({cmd_ready, busy, done, err, err_code, rd_data, dut_data_out,
        dut_data_oe, dut_verify, dut_prog, dut_vpp, dut_ia}), 1 << 26);
    rst = 1'b0;
    for (int i = 0; i < 12; i++)
      exec($sformatf("vec%0d", i), tbl[i].c, tbl[i].d, tbl[i].rdy, tbl[i].m, tbl[i].bad, 1'b0,
           tbl[i].off, tbl[i].ec, tbl[i].p, tbl[i].plow, tbl[i].ia, tbl[i].rd, tbl[i].vpp, tbl[i].prog);
    exec("held_valid", 3'd3, 8'h77, 1'b1, 0, 8'h00, 1'b1, 10, 0, 1, 4, 1, 8'h77, 1'b0, 1'b1);
    exec("vpp_on", 3'd5, 8'h00, 1'b1, 0, 8'h00, 1'b0, 0, 0, 0, 0, 0, 8'h77, 1'b1, 1'b1);
    @(negedge osc);
    cmd = 3'd4;
    cmd_valid = 1'b1;
    @(posedge osc);
    #1;
    cmd_valid = 1'b0;
    repeat (8) @(negedge osc);
    chk("erase_mid", int'({dut_prog, dut_vpp, busy}), 3);
    #2;
    c0 = cyc;
    rst = 1'b1;
    #1;
    chk("erase_rst_pins", int'({dut_prog, dut_vpp, cmd_ready, busy}), 2);
    chk("erase_rst_no_edge", cyc, c0);
    nd = 0;
    repeat (3) begin
      @(negedge osc);
      if (done) nd++;
    end
    chk("erase_rst_no_done", nd, 0);
    rst = 1'b0;
    pm = 1'b1;
    vm = 1'b0;
    rdm = 8'h00;
    exec("rst_prog_high", 3'd1, 8'h00, 1'b1, 0, 8'h00, 1'b0, 0, 0, 0, 0, 0, 8'h00, 1'b0, 1'b1);
    for (int n = 0; n < 60; n++) begin
      c = pick[$urandom_range(0, 9)];
      d = 8'($urandom_range(0, 255));
      rdy = $urandom_range(0, 3) != 0;
      m = $urandom_range(0, 3);
      bad = d ^ 8'($urandom_range(1, 255));
      off = 0;
      ec = 0;
      ia = 0;
      att = 0;
      if (c == 3'd3) begin
        if (!rdy) begin
          att = 1;
          off = P + R + (NP - 1) * (PL + 1) + 1;
          ec = 1;
        end else begin
          succ = m <= RT;
          att = (m < RT ? m : RT) + 1;
          off = att * (P + R + 1 + V) + (succ ? IA : 0);
          ec = succ ? 0 : 2;
          ia = succ ? IA : 0;
          rdm = succ ? d : bad;
        end
        pm = 1'b1;
      end else if (c == 3'd7) begin
        off = V + IA;
        ia = IA;
        rdm = d;
      end else if (c == 3'd4) begin
        off = ER;
        att = pm ? 1 : 0;
        pm = 1'b1;
      end else if (c == 3'd5) vm = 1'b1;
      else if (c == 3'd6) vm = 1'b0;
      exec($sformatf("rand%0d_cmd%0d", n, c), c, d, rdy, m, bad, 1'b0, off, ec, att,
           c == 3'd4 ? ER : att * P, ia, rdm, vm, pm);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mcs51_prog_sequencer.md
# mcs51_prog_sequencer

Parametrised programming-pulse sequencer for the MCS-51 flash family (AT89C1051/2051/4051 class). Owns PROG, VPP enable and address-increment strobes, and runs program (with verify and retry), erase, read and VPP commands from a single command handshake. Sits between the host register decoder and the ZIF pin buffers. Adds four things: timing configured by parameters, read-back verify with bounded retries, an automatic address-increment pulse, and coded errors.

## Interface
- DATA_WIDTH, 8, DUT data bus width.
- PULSE_CYCLES, 24, PROG low time per program pulse.
- RECOVER_CYCLES, 2, PROG high time before the first ready sample.
- POLL_CYCLES, 4800, wait between ready samples.
- READY_POLLS, 12, maximum ready samples before timeout (≥1).
- VERIFY_CYCLES, 2, read-mode settle time before compare.
- MAX_RETRIES, 3, extra program pulses allowed after a verify mismatch.
- IA_CYCLES, 2, address-increment pulse width.
- ERASE_CYCLES, 240000, PROG low time for chip erase.
- AUTO_INC, 1, pulse dut_ia after a successful PROGRAM or READ.
- osc  in  1  12 MHz clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high when idle; a command is accepted on a rising edge with cmd_valid && cmd_ready.
- cmd  in  3  0 NOP, 1 PROG_HIGH, 2 PROG_LOW, 3 PROGRAM, 4 ERASE, 5 VPP_ON, 6 VPP_OFF, 7 READ.
- wr_data  in  DATA_WIDTH  byte to program; latched on accept.
- rd_data  out  DATA_WIDTH  last byte read or verified.
- busy  out  1  command executing.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  last command failed.
- err_code  out  2  0 ok, 1 ready timeout, 2 verify failed.
- dut_rdy  in  1  asynchronous RDY/BSY pin; double-flop synchronised internally.
- dut_data_in  in  DATA_WIDTH  DUT port-1 sample.
- dut_data_out  out  DATA_WIDTH  byte driven to the DUT.
- dut_data_oe  out  1  drive enable for dut_data_out.
- dut_verify  out  1  request read mode; the pin-mapping glue decodes it.
- dut_prog, dut_vpp, dut_ia  out  1  PROG, VPP and XTAL1 increment strobes.

## Operation
- Reset values: every output is 0 except cmd_ready=1. All state and counters clear, asynchronously.
- On accept: latch cmd and wr_data, clear err and err_code, then cmd_ready=0 and busy=1.
- States: IDLE, PULSE, RECOVER, POLL, WAIT, VERIFY, INC, ERASE, FINISH.
- NOP, PROG_HIGH, PROG_LOW, VPP_ON, VPP_OFF go straight to FINISH, setting dut_prog or dut_vpp as named. dut_prog and dut_vpp hold their values between commands.
- PROGRAM:
  - PULSE: dut_data_oe=1, dut_prog=0.
  - RECOVER: dut_prog=1.
  - POLL: sample the synchronised ready. If 1, go to VERIFY. If 0 and fewer than READY_POLLS samples taken, go to WAIT, then back to POLL. If 0 on sample READY_POLLS: err_code=1, go to FINISH.
  - VERIFY: dut_data_oe=0, dut_verify=1. On the last cycle, capture rd_data and compare it to the latched byte.
  - Match: go to INC if AUTO_INC, else FINISH.
  - Mismatch with retries < MAX_RETRIES: increment retries, go back to PULSE.
  - Mismatch with retries exhausted: err_code=2, go to FINISH.
- READ: VERIFY without compare, then INC per AUTO_INC.
- ERASE: dut_prog=0 for ERASE_CYCLES, then dut_prog=1, then FINISH. The host sets the mode pins and VPP beforehand.
- INC: dut_ia=1.
- FINISH: done=1, busy=0, cmd_ready=1, dut_verify=0, dut_data_oe=0. err = (err_code≠0).
- cmd_valid while busy is ignored; it is not queued.
- Reset mid-command: dut_prog and dut_vpp drop to 0 immediately, the command is lost and done does not fire.

## Timing
- Each state lasts exactly its parameter count in cycles. POLL and FINISH last 1 cycle. Outputs are registered and change on the state-entry edge.
- Accept edge E0 enters the first state. Non-sequenced commands give done in the cycle after E0.
- PROGRAM, ready high at the first sample, verify match: done after edge E0+PULSE+RECOVER+1+VERIFY+IA. With defaults that is E0+31.
- Ready samples fall at E0+P+R+k·(POLL_CYCLES+1), for k = 0 .. READY_POLLS−1.
- Each retry adds PULSE+RECOVER+polls+VERIFY.
- The dut_rdy synchroniser adds 2 cycles of input latency, which the RECOVER time must cover.
- Counters are sized $clog2(max parameter)+1 and never wrap. Every parameter must be ≥1.

## Test plan
Bench parameters: P=4, R=2, POLL=8, POLLS=3, V=2, IA=1, RETRIES=2, ERASE=16.
- PROGRAM 0xA5, dut_rdy=1, dut_data_in=0xA5 -> dut_prog low for exactly 4 cycles; dut_ia high for 1 cycle; done after E0+10; err=0.
- PROGRAM with dut_rdy stuck at 0 -> samples at E0+6, +15, +24; done after E0+25; err_code=1; no dut_ia pulse.
- PROGRAM 0x3C, dut_data_in=0x00 for the first two verifies then 0x3C -> 3 PROG pulses; err=0; rd_data=0x3C.
- PROGRAM 0x3C, dut_data_in held at 0xFF -> 3 PROG pulses; err_code=2; rd_data=0xFF.
- VPP_ON, ERASE, then rst asserted 8 cycles into the erase -> dut_prog and dut_vpp go to 0 with no clock edge; no done pulse; cmd_ready=1.
- cmd_valid held high during a PROGRAM with cmd=5 -> ignored; dut_vpp unchanged; exactly one done pulse.
